jk_excite_seq: RTL

- Sequencer/driver for a bank of WIDTH JK flip-flops, one JKff per bit.
- Holds a programmed list of target states.
- Generates the J/K excitation that moves the bank from its current state to each target in turn.
- Reads Q/Q_L back and checks every step. It is the active driving end of the JK flip-flop interface and is used as a self-checking stimulus source and as a JK-based register controller.

---
 rtl/jk_excite_seq_if.sv | 16 +
 rtl/jk_excite_seq.sv | 76 +++++++
 2 files changed

// File: rtl/jk_excite_seq_if.sv
// jk_excite_seq_if: host command/status and JK-bank drive/feedback signals of the excitation sequencer
interface jk_excite_seq_if #(parameter int WIDTH = 4, parameter int ADDR_W = 3);
  logic wr_en, clr, start, loop, busy, done, err, full;
  logic [WIDTH-1:0] wr_data, q_fb, q_l_fb, j, k;
  logic [1:0] err_code;
  logic [ADDR_W-1:0] err_step;
  logic [ADDR_W:0] count;
  modport master(
    input wr_en, wr_data, clr, start, loop, q_fb, q_l_fb,
    output j, k, busy, done, err, err_code, err_step, count, full
  );
  modport slave(
    output wr_en, wr_data, clr, start, loop, q_fb, q_l_fb,
    input j, k, busy, done, err, err_code, err_step, count, full
  );
endinterface

// File: rtl/jk_excite_seq.sv
// jk_excite_seq: walks a JK flip-flop bank through a programmed list of target states and checks each step
module jk_excite_seq #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int ADDR_W = 3,
  parameter int USE_TOGGLE = 0
) (
  input logic clk,
  input logic rst,
  jk_excite_seq_if.master b
);
  typedef enum logic [1:0] {IDLE, SETUP, APPLY, CHECK} state_t;
  localparam logic [ADDR_W:0] ONE = 1;
  state_t state, state_nx;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] i, i_nx;
  logic go, wr_ok, last;
  logic [1:0] code;
  function automatic logic [2*WIDTH-1:0] excite(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] t);
    logic [WIDTH-1:0] d;
    d = q ^ t;
    return USE_TOGGLE != 0 ? {d, d} : {d & t, d & ~t};
  endfunction
  assign go = b.start && b.count != '0;
  assign wr_ok = state == IDLE && !b.clr && !go && b.wr_en && !b.full;
  assign last = {1'b0, i} == b.count - ONE;
  assign i_nx = last ? '0 : i + ADDR_W'(1);
  assign code = {b.q_l_fb != ~b.q_fb, b.q_fb != mem[i]};
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE  ? (!b.clr && go ? SETUP : IDLE) :
               state == SETUP ? APPLY :
               state == APPLY ? CHECK :
               (last && !b.loop ? IDLE : APPLY);
  assign b.busy = state != IDLE;
  assign b.full = b.count == (ADDR_W+1)'(DEPTH);
  always_ff @(posedge clk)
    if (!rst && wr_ok) mem[b.count[ADDR_W-1:0]] <= b.wr_data;
  // J/K default to hold (0/0) every cycle; only SETUP and CHECK exits load an excitation
  always_ff @(posedge clk) begin
    if (rst) begin
      b.j <= '0;
      b.k <= '0;
      b.done <= 1'b0;
      b.err <= 1'b0;
      b.err_code <= '0;
      b.err_step <= '0;
      b.count <= '0;
      i <= '0;
    end else begin
      {b.j, b.k} <= '0;
      b.done <= 1'b0;
      if (state == IDLE && (b.clr || go)) begin
        b.err <= 1'b0;
        b.err_code <= '0;
        b.err_step <= '0;
        i <= '0;
      end
      if (state == IDLE && b.clr) b.count <= '0;
      else if (wr_ok) b.count <= b.count + ONE;
      if (state == SETUP) {b.j, b.k} <= excite(b.q_fb, mem[i]);
      if (state == CHECK) begin
        i <= i_nx;
        if (code != 2'b00) begin
          b.err_code <= b.err_code | code;
          if (!b.err) begin
            b.err <= 1'b1;
            b.err_step <= i;
          end
        end
        if (last && !b.loop) b.done <= 1'b1;
        else {b.j, b.k} <= excite(b.q_fb, mem[i_nx]);
      end
    end
  end
endmodule
